// File: rtl/transmitter_fsm.sv
// ---------------------------------------------------------------------------
// transmitter_fsm
//   Command-driven serial transmitter holding a 2x4 matrix of 8-bit cells.
//   A 3-bit action code writes a byte into the addressed cell, clears the
//   matrix, or streams one cell, one row or the whole matrix out of tx as
//   UART-style frames (start 0, 8 data bits LSB first, stop 1).
//
// Ports
//   clk            : single clock, all logic on posedge
//   rst            : synchronous active-high reset (clears memory, aborts send)
//   d0..d7         : write data, d0 = LSB
//   row            : row address (0..1)
//   col0, col1     : column address {col1,col0} (0..3)
//   action0..2     : action code {action2,action1,action0}
//                    0 nop, 1 write, 2 send cell, 3 send row, 4 send all,
//                    5 clear, 6/7 nop
//   tx             : serial line, idle high
//   busy           : high while any frame is in progress
//   cell0..cell7   : bits of the cell at the live (row,col) address
// ---------------------------------------------------------------------------
module transmitter_fsm #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d0,
  input  logic d1,
  input  logic d2,
  input  logic d3,
  input  logic d4,
  input  logic d5,
  input  logic d6,
  input  logic d7,
  input  logic row,
  input  logic col0,
  input  logic col1,
  input  logic action0,
  input  logic action1,
  input  logic action2,
  output logic tx,
  output logic busy,
  output logic cell0,
  output logic cell1,
  output logic cell2,
  output logic cell3,
  output logic cell4,
  output logic cell5,
  output logic cell6,
  output logic cell7
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] ACT_WRITE    = 3'd1;
  localparam logic [2:0] ACT_SEND_ONE = 3'd2;
  localparam logic [2:0] ACT_SEND_ROW = 3'd3;
  localparam logic [2:0] ACT_SEND_ALL = 3'd4;
  localparam logic [2:0] ACT_CLEAR    = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t state, state_next;

  logic [7:0]       mem [8];
  logic [2:0]       addr;
  logic [7:0]       wdata;
  logic [2:0]       action;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic [2:0]       cur_idx;
  logic [2:0]       last_idx;
  logic             baud_last;
  logic             last_frame;
  logic             is_send;

  assign addr   = {row, col1, col0};
  assign wdata  = {d7, d6, d5, d4, d3, d2, d1, d0};
  assign action = {action2, action1, action0};

  assign baud_last  = (baud_cnt == BAUD_LAST);
  assign last_frame = (cur_idx == last_idx);
  assign is_send    = (action == ACT_SEND_ONE) || (action == ACT_SEND_ROW) ||
                      (action == ACT_SEND_ALL);

  // Cell read port follows the live address inputs with no register delay.
  assign {cell7, cell6, cell5, cell4, cell3, cell2, cell1, cell0} = mem[addr];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Actions are only looked at in IDLE, so anything that
  // arrives mid-send is simply dropped.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (is_send) state_next = START;
      START: if (baud_last) state_next = DATA;
      DATA:  if (baud_last && (bit_cnt == 3'd7)) state_next = STOP;
      STOP:  if (baud_last) state_next = last_frame ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: memory, baud/bit counters and the frame shift register.
  // A multi-frame send is tracked as a cell index range [cur_idx, last_idx];
  // each following frame's byte is loaded as the previous stop bit ends so
  // that frames run back to back.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        mem[i] <= 8'd0;
      end
      baud_cnt <= '0;
      bit_cnt  <= 3'd0;
      shreg    <= 8'd0;
      cur_idx  <= 3'd0;
      last_idx <= 3'd0;
    end else if (state == IDLE) begin
      baud_cnt <= '0;
      bit_cnt  <= 3'd0;
      case (action)
        ACT_WRITE: mem[addr] <= wdata;
        ACT_SEND_ONE: begin
          cur_idx  <= addr;
          last_idx <= addr;
          shreg    <= mem[addr];
        end
        ACT_SEND_ROW: begin
          cur_idx  <= {row, 2'b00};
          last_idx <= {row, 2'b11};
          shreg    <= mem[{row, 2'b00}];
        end
        ACT_SEND_ALL: begin
          cur_idx  <= 3'd0;
          last_idx <= 3'd7;
          shreg    <= mem[0];
        end
        ACT_CLEAR: begin
          for (int i = 0; i < 8; i++) begin
            mem[i] <= 8'd0;
          end
        end
        default: ;
      endcase
    end else begin
      baud_cnt <= baud_last ? '0 : baud_cnt + 1'b1;
      if (baud_last) begin
        if (state == DATA) begin
          shreg   <= shreg >> 1;
          bit_cnt <= bit_cnt + 3'd1;
        end
        if ((state == STOP) && !last_frame) begin
          cur_idx <= cur_idx + 3'd1;
          shreg   <= mem[cur_idx + 3'd1];
        end
      end
    end
  end

  // Outputs decoded from the registered state, so tx/busy change only on
  // clock edges.
  always_comb begin
    tx   = 1'b1;
    busy = 1'b0;
    case (state)
      START: begin
        tx   = 1'b0;
        busy = 1'b1;
      end
      DATA: begin
        tx   = shreg[0];
        busy = 1'b1;
      end
      STOP: begin
        tx   = 1'b1;
        busy = 1'b1;
      end
      default: begin
        tx   = 1'b1;
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_transmitter_fsm.sv
// ---------------------------------------------------------------------------
// tb_transmitter_fsm
//   Directed bench for transmitter_fsm. A behavioural model keeps its own copy
//   of the cell matrix and turns every accepted send into a queue of expected
//   tx samples (one entry per clock); the line is idle exactly when that
//   queue is empty. The DUT is compared against the model every cycle, and a
//   set of hand-computed literals pins the model itself.
// ---------------------------------------------------------------------------
module tb_transmitter_fsm;

  localparam int CPB = 4;

  logic       clk;
  logic       rst;
  logic [7:0] dbyte;
  logic       row;
  logic [1:0] col;
  logic [2:0] act;
  logic       tx;
  logic       busy;
  wire  [7:0] cellv;

  int vectors;
  int miscompares;
  bit check_en;

  // Model state
  logic [7:0] mmem [8];
  bit         mq [$];

  transmitter_fsm #(.CLKS_PER_BIT(CPB)) dut (
    .clk    (clk),
    .rst    (rst),
    .d0     (dbyte[0]),
    .d1     (dbyte[1]),
    .d2     (dbyte[2]),
    .d3     (dbyte[3]),
    .d4     (dbyte[4]),
    .d5     (dbyte[5]),
    .d6     (dbyte[6]),
    .d7     (dbyte[7]),
    .row    (row),
    .col0   (col[0]),
    .col1   (col[1]),
    .action0(act[0]),
    .action1(act[1]),
    .action2(act[2]),
    .tx     (tx),
    .busy   (busy),
    .cell0  (cellv[0]),
    .cell1  (cellv[1]),
    .cell2  (cellv[2]),
    .cell3  (cellv[3]),
    .cell4  (cellv[4]),
    .cell5  (cellv[5]),
    .cell6  (cellv[6]),
    .cell7  (cellv[7])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One UART frame: start 0, data LSB first, stop 1, each held CPB clocks.
  function automatic void pushFrame(input logic [7:0] b);
    for (int k = 0; k < 10; k++) begin
      bit v;
      v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      for (int r = 0; r < CPB; r++) mq.push_back(v);
    end
  endfunction

  // Model update on each edge, then a per-cycle comparison just after it.
  always @(posedge clk) begin
    bit drop;
    if (rst) begin
      mq.delete();
      for (int i = 0; i < 8; i++) mmem[i] = 8'd0;
    end else if (mq.size() != 0) begin
      drop = mq.pop_front();
    end else begin
      case (act)
        3'd1: mmem[{row, col}] = dbyte;
        3'd2: pushFrame(mmem[{row, col}]);
        3'd3: for (int c = 0; c < 4; c++) pushFrame(mmem[int'(row) * 4 + c]);
        3'd4: for (int c = 0; c < 8; c++) pushFrame(mmem[c]);
        3'd5: for (int i = 0; i < 8; i++) mmem[i] = 8'd0;
        default: ;
      endcase
    end
    #1;
    if (check_en) begin
      checkOutput("cycle", {6'd0, busy, tx, cellv},
                  {6'd0, mq.size() != 0, (mq.size() != 0) ? mq[0] : 1'b1,
                   mmem[{row, col}]});
    end
  end

  task automatic applyStimulus(input logic [2:0] a, input logic [7:0] d,
                               input logic r, input logic [1:0] c);
    @(negedge clk);
    act   = a;
    dbyte = d;
    row   = r;
    col   = c;
  endtask

  task automatic readCell(input int idx, input logic [7:0] expected);
    @(negedge clk);
    row = idx[2];
    col = idx[1:0];
    #1;
    checkOutput($sformatf("cell%0d", idx), {8'd0, cellv}, {8'd0, expected});
  endtask

  // Called right after a send action is driven: releases the action once it
  // has been accepted, captures the first frame mid-bit and counts busy cycles.
  task automatic measureSend(output logic [9:0] frame, output int cycles);
    int n;
    frame = '0;
    n = 0;
    @(posedge clk);
    #1;
    act = 3'd0;
    while (busy && n < 1000) begin
      if (n < 10 * CPB && (n % CPB) == 1) frame[n / CPB] = tx;
      n++;
      @(posedge clk);
      #1;
    end
    cycles = n;
    @(negedge clk);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_wait", {15'd0, busy}, 16'd0);
  endtask

  initial begin
    logic [9:0] frame;
    int         cycles;

    vectors     = 0;
    miscompares = 0;
    check_en    = 1'b0;
    rst   = 1'b1;
    act   = 3'd0;
    dbyte = 8'd0;
    row   = 1'b0;
    col   = 2'd0;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_en = 1'b1;
    #1;
    checkOutput("reset_txbusy", {14'd0, busy, tx}, 16'h0001);
    for (int i = 0; i < 8; i++) readCell(i, 8'h00);

    // Write 0xAA to (0,0)
    applyStimulus(3'd1, 8'hAA, 1'b0, 2'd0);
    applyStimulus(3'd0, 8'h00, 1'b0, 2'd0);
    readCell(0, 8'hAA);
    readCell(1, 8'h00);
    readCell(4, 8'h00);

    // Single send of 0xAA
    applyStimulus(3'd2, 8'h00, 1'b0, 2'd0);
    measureSend(frame, cycles);
    checkOutput("single_frame", {6'd0, frame}, {6'd0, 10'b1101010100});
    checkOutput("single_busy", cycles[15:0], 16'd40);
    checkOutput("single_idle", {14'd0, busy, tx}, 16'h0001);

    // Row send: 0x01..0x04 into row 1
    for (int c = 0; c < 4; c++) applyStimulus(3'd1, 8'(c + 1), 1'b1, 2'(c));
    applyStimulus(3'd3, 8'h00, 1'b1, 2'd0);
    measureSend(frame, cycles);
    checkOutput("row_frame0", {6'd0, frame}, {6'd0, 10'b1000000010});
    checkOutput("row_busy", cycles[15:0], 16'd160);

    // Busy lockout: writes during a send are dropped
    applyStimulus(3'd2, 8'h00, 1'b1, 2'd0);
    applyStimulus(3'd1, 8'hFF, 1'b1, 2'd0);
    repeat (5) @(negedge clk);
    act = 3'd0;
    waitIdle();
    readCell(4, 8'h01);
    readCell(7, 8'h04);

    // Clear
    applyStimulus(3'd5, 8'h00, 1'b0, 2'd0);
    applyStimulus(3'd0, 8'h00, 1'b0, 2'd0);
    for (int i = 0; i < 8; i++) readCell(i, 8'h00);

    // Send-all with two non-zero cells
    applyStimulus(3'd1, 8'h81, 1'b0, 2'd0);
    applyStimulus(3'd1, 8'h5A, 1'b1, 2'd3);
    applyStimulus(3'd4, 8'h00, 1'b0, 2'd0);
    measureSend(frame, cycles);
    checkOutput("all_frame0", {6'd0, frame}, {6'd0, 10'b1100000010});
    checkOutput("all_busy", cycles[15:0], 16'd320);

    // Codes 6 and 7 do nothing
    applyStimulus(3'd6, 8'h33, 1'b0, 2'd0);
    applyStimulus(3'd7, 8'h33, 1'b0, 2'd0);
    applyStimulus(3'd0, 8'h00, 1'b0, 2'd0);
    #1;
    checkOutput("nop_busy", {15'd0, busy}, 16'd0);
    readCell(0, 8'h81);

    // Reset in the middle of the data bits
    applyStimulus(3'd2, 8'h00, 1'b0, 2'd0);
    applyStimulus(3'd0, 8'h00, 1'b0, 2'd0);
    repeat (8) @(negedge clk);
    #1;
    checkOutput("midsend_busy", {15'd0, busy}, 16'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_txbusy", {14'd0, busy, tx}, 16'h0001);
    checkOutput("abort_cell", {8'd0, cellv}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    readCell(7, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
